serial_subtractor_16bit: RTL and testbench

Multi-cycle two's-complement subtractor, the inverse companion to the ripple adder datapath. It computes diff = a - b - bin one DIGIT-wide slice per cycle, LSB slice first. Operands come in over a valid/ready handshake, and results leave over a second valid/ready handshake with borrow, signed-overflow and zero flags. It sits in the arithmetic unit wherever area matters more than single-cycle latency.

---
 rtl/serial_subtractor_16bit_pkg.sv | 22 ++
 rtl/serial_subtractor_16bit_sub_slice.sv | 19 +
 rtl/serial_subtractor_16bit.sv | 126 ++++++++++++
 tb/tb_serial_subtractor_16bit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared arithmetic definitions: FSM state encoding, default datapath
// geometry and the signed-overflow rule used by the subtractor and ripple adder.
package serial_subtractor_16bit_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Subtraction overflows only when operand signs differ and the result sign
  // departs from the minuend; the adder calls this with b's sign inverted.
  function automatic logic calcOverflow(input logic aMsb,
                                        input logic bMsb,
                                        input logic diffMsb);
    return (aMsb != bMsb) && (diffMsb != aMsb);
  endfunction

endpackage

// File: rtl/serial_subtractor_16bit_sub_slice.sv
// One DIGIT-wide subtract slice: a + ~b + cin, with carry-out.
// The carry-out is the inverse of the slice borrow.
module serial_subtractor_16bit_sub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] diff_o,
  output logic             cout_o
);

  logic [DIGIT:0] sum;

  assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{DIGIT{1'b0}}, cin_i};
  assign diff_o = sum[DIGIT-1:0];
  assign cout_o = sum[DIGIT];

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Multi-cycle subtractor: diff = a - b - bin, one DIGIT slice per cycle,
// LSB slice first, with valid/ready handshakes on both sides.
module serial_subtractor_16bit
  import serial_subtractor_16bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(STEPS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aOp_q, aOp_d;
  logic [WIDTH-1:0] bOp_q, bOp_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] sliceCnt_q, sliceCnt_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] sliceA, sliceB, sliceDiff;
  logic             sliceCout;

  assign sliceA = aOp_q[int'(sliceCnt_q)*DIGIT +: DIGIT];
  assign sliceB = bOp_q[int'(sliceCnt_q)*DIGIT +: DIGIT];

  serial_subtractor_16bit_sub_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .diff_o (sliceDiff),
    .cout_o (sliceCout)
  );

  always_comb begin
    state_d    = state_q;
    aOp_d      = aOp_q;
    bOp_d      = bOp_q;
    diff_d     = diff_q;
    sliceCnt_d = sliceCnt_q;
    carry_d    = carry_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aOp_d      = a;
          bOp_d      = b;
          carry_d    = ~bin;
          sliceCnt_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        diff_d[int'(sliceCnt_q)*DIGIT +: DIGIT] = sliceDiff;
        carry_d = sliceCout;
        // Flags are taken from the completed result, including this last slice.
        if (sliceCnt_q == LAST_SLICE) begin
          state_d = DONE;
          bout_d  = ~sliceCout;
          ovf_d   = calcOverflow(aOp_q[WIDTH-1], bOp_q[WIDTH-1], diff_d[WIDTH-1]);
          zero_d  = (diff_d == '0);
        end else begin
          sliceCnt_d = sliceCnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aOp_q      <= '0;
      bOp_q      <= '0;
      diff_q     <= '0;
      sliceCnt_q <= '0;
      carry_q    <= 1'b0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aOp_q      <= aOp_d;
      bOp_q      <= bOp_d;
      diff_q     <= diff_d;
      sliceCnt_q <= sliceCnt_d;
      carry_q    <= carry_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench for serial_subtractor_16bit: directed corner cases,
// backpressure, mid-run reset and random operands against an arithmetic model.
module tb_serial_subtractor_16bit;

  localparam int STEPS   = 4;
  localparam int TIMEOUT = 20;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, bin;
  logic        out_valid, out_ready;
  logic        bout, overflow, zero;
  logic [15:0] a, b, diff;

  int compared   = 0;
  int mismatched = 0;

  vec_t dirVecs[6] = '{
    '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0},
    '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0},
    '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0},
    '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1},
    '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0}
  };

  always #5 clk = ~clk;

  serial_subtractor_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  // Arithmetic reference: 17-bit unsigned difference and signed integer range.
  task automatic refModel(input logic [15:0] ra, input logic [15:0] rb, input logic rbin,
                          output logic [15:0] eDiff, output logic eBout,
                          output logic eOvf, output logic eZero);
    logic [16:0] full;
    int          sd;
    full  = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
    eDiff = full[15:0];
    eBout = full[16];
    sd    = int'($signed(ra)) - int'($signed(rb)) - (rbin ? 1 : 0);
    eOvf  = (sd > 32767) || (sd < -32768);
    eZero = (eDiff == 16'h0000);
  endtask

  // Presents operands and returns #1 after the accept edge.
  task automatic applyStimulus(input logic [15:0] sa, input logic [15:0] sb, input logic sbin);
    int n;
    n = 0;
    while (!in_ready && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready before accept", in_ready, 1);
    a = sa; b = sb; bin = sbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
  endtask

  task automatic waitResult(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < TIMEOUT);
    checkOutput({tag, " latency"}, n, STEPS);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] eDiff, input logic eBout,
                             input logic eOvf, input logic eZero);
    checkOutput({tag, " diff"}, diff, eDiff);
    checkOutput({tag, " bout"}, bout, eBout);
    checkOutput({tag, " overflow"}, overflow, eOvf);
    checkOutput({tag, " zero"}, zero, eZero);
    checkOutput({tag, " in_ready in DONE"}, in_ready, 0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after consume"}, out_valid, 0);
    checkOutput({tag, " in_ready after consume"}, in_ready, 1);
  endtask

  initial begin
    logic [15:0] eDiff, ra, rb;
    logic        eBout, eOvf, eZero, rbin;
    int          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset diff", diff, 0);
    checkOutput("reset bout", bout, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset zero", zero, 0);
    rst = 1'b0;

    foreach (dirVecs[i]) begin
      applyStimulus(dirVecs[i].a, dirVecs[i].b, dirVecs[i].bin);
      waitResult($sformatf("dir%0d", i));
      checkResult($sformatf("dir%0d", i), dirVecs[i].d, dirVecs[i].bo, dirVecs[i].ov, dirVecs[i].z);
      consume($sformatf("dir%0d", i));
    end

    // Backpressure: result held, new operands ignored until consumed.
    applyStimulus(16'h1111, 16'h0222, 1'b0);
    waitResult("bp first");
    refModel(16'h1111, 16'h0222, 1'b0, eDiff, eBout, eOvf, eZero);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; bin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid held", out_valid, 1);
      checkResult("bp hold", eDiff, eBout, eOvf, eZero);
    end
    consume("bp first");
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult("bp second");
    checkResult("bp second", 16'h5555, 1'b0, 1'b1, 1'b0);
    consume("bp second");

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i == 0) rb = ra;
      refModel(ra, rb, rbin, eDiff, eBout, eOvf, eZero);
      applyStimulus(ra, rb, rbin);
      waitResult($sformatf("rnd%0d", i));
      checkResult($sformatf("rnd%0d", i), eDiff, eBout, eOvf, eZero);
      consume($sformatf("rnd%0d", i));
    end

    // Reset while slice 2 is being processed.
    applyStimulus(16'hBEEF, 16'h1234, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort in_ready in RUN", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort diff", diff, 0);
    checkOutput("abort flags", {bout, overflow, zero}, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("abort no result", seen, 0);

    refModel(16'h4321, 16'h0FFF, 1'b1, eDiff, eBout, eOvf, eZero);
    applyStimulus(16'h4321, 16'h0FFF, 1'b1);
    waitResult("post abort");
    checkResult("post abort", eDiff, eBout, eOvf, eZero);
    consume("post abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
